spi_adc_frame_rx: RTL
=====================

Name: spi_adc_frame_rx

Overview:
- Parametrised SPI-slave frame receiver for external ADC streams. It is the successor to the fixed 16-bit, single-mode SPI receive path in the UART/SPI top.
- Adds the following over the fixed path:
  - configurable frame width and channel-ID field;
  - runtime CPOL/CPHA mode;
  - CS polarity parameter;
  - short/long frame detection;
  - output FIFO with valid/ready handshake and sticky overflow.
- Sits between the pad-level SPI inputs (sclk/cs/sdi) and the on-chip consumer, such as the UART TX path or the multiplier.

Parameters:
- FRAME_W, 16, bits per SPI frame, MSB first; legal range 8..32.
- CH_BITS, 4, width of the channel-ID field, taken from the frame LSBs; legal range 1..FRAME_W-4.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, synchroniser flops on sclk/cs/sdi; legal range 2..3.
- CS_ACTIVE, 1, level of spi_cs that marks an active frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpol  in  1  SPI clock polarity; latched at frame start
- cpha  in  1  SPI clock phase; latched at frame start
- spi_sclk  in  1  external SPI clock, asynchronous
- spi_cs  in  1  external chip select, asynchronous; active level is CS_ACTIVE
- spi_sdi  in  1  serial data from the ADC, asynchronous
- frame_data  out  FRAME_W-CH_BITS  sample field at the FIFO head
- frame_ch  out  CH_BITS  channel ID at the FIFO head
- frame_valid  out  1  FIFO not empty
- frame_ready  in  1  consumer accepts the head entry
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
- busy  out  1  synchronised CS is active
- frame_err  out  1  one-cycle pulse: frame ended with bit count != FRAME_W
- overflow  out  1  sticky: a frame was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- **Reset:** while rst=1, all state clears immediately. Outputs: frame_data=0, frame_ch=0, frame_valid=0, fifo_count=0, busy=0, frame_err=0, overflow=0. A frame in progress at reset is discarded. After reset release, reception starts only at the next CS assertion edge; a CS already held active at release is ignored until it deasserts.
- **Synchronisation:** spi_sclk, spi_cs and spi_sdi each pass through SYNC_STAGES flops. Edge detection uses one further register on the synchronised sclk and cs. Required ratio: each sclk phase lasts at least SYNC_STAGES+2 clk cycles.
- **State machine:** IDLE -> ACTIVE -> DONE -> IDLE.
  - **IDLE:** on a synchronised CS transition to CS_ACTIVE:
    - latch cpol/cpha;
    - clear the bit counter and shift register;
    - go to ACTIVE.
  - **ACTIVE:** sample edge is sclk rising when cpol^cpha==0, falling otherwise. On each sample edge:
    - shift the synchronised sdi into the LSB;
    - increment the bit counter, saturating at FRAME_W+1.
    - On CS deassertion, go to DONE.
  - **DONE:** lasts one cycle.
    - If count==FRAME_W and FIFO not full: push {data, ch}.
    - If count==FRAME_W and FIFO full: drop the frame and set overflow.
    - If count!=FRAME_W (short or long frame): pulse frame_err and push nothing.
    - Then return to IDLE.
- **busy:** equals synchronised CS == CS_ACTIVE.
- **Latency:** the FIFO push happens in the DONE cycle. frame_valid rises on the following clk edge when the FIFO was empty.
- **Frame split:** frame_ch = frame[CH_BITS-1:0]; frame_data = frame[FRAME_W-1:CH_BITS].
- **FIFO:** first-word-fall-through.
  - Pop occurs when frame_valid && frame_ready.
  - Push and pop in the same cycle: both happen and fifo_count is unchanged. This holds even when the FIFO is full: the pop frees the slot, the push succeeds, and overflow is not set.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - frame_ready while empty is ignored.
- **overflow:** cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, the set wins.
- **Mode inputs:** cpol/cpha changes during ACTIVE have no effect until the next frame.

Test Plan:
- **Mode 0, defaults:** sclk period 50 clk; send 16-bit frames 0x0000..0x000F, MSB first; frame_ready=1. Required: 16 pops with frame_ch=0..15 in order and frame_data=0; frame_err=0; overflow=0.
- **All four modes:** cpol/cpha = 00, 01, 10, 11, each sending 0xABC5. Required in every mode: frame_data=0xABC, frame_ch=5.
- **Short and long frames:** a 15-bit frame, then a 17-bit frame. Required: exactly one frame_err pulse per frame; fifo_count stays 0.
- **Overflow:** frame_ready=0; send 5 frames with FIFO_DEPTH=4.
  - Required: fifo_count=4; overflow=1; the head is frame 1.
  - Then pulse ovf_clr and drain. Required: overflow=0; the 4 entries pop in order.
- **Full FIFO with simultaneous pop:** FIFO full, frame_ready=1 in the DONE cycle of a 5th frame. Required: overflow=0; fifo_count stays 4; the 5th frame is present after draining.
- **Reset mid-frame:** assert rst after 8 bits of a frame, release while CS is still active, then send a full frame. Required:
  - all outputs are 0 during reset;
  - the interrupted frame is not pushed;
  - the next full frame is received correctly.
- **Parameter variant:** FRAME_W=24, CH_BITS=3, CS_ACTIVE=0; send 0x123457. Required: frame_data=0x2468A, frame_ch=7.

Source files
------------

// File: rtl/spi_adc_frame_rx.sv
// SPI-slave frame receiver for external ADC streams: synchronises the pad
// signals, assembles MSB-first frames and queues {sample, channel} in a FWFT FIFO.
module spi_adc_frame_rx #(
    parameter int   FRAME_W     = 16,
    parameter int   CH_BITS     = 4,
    parameter int   FIFO_DEPTH  = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic CS_ACTIVE   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          spi_sclk,
    input  logic                          spi_cs,
    input  logic                          spi_sdi,
    output logic [FRAME_W-CH_BITS-1:0]    frame_data,
    output logic [CH_BITS-1:0]            frame_ch,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(FRAME_W + 2);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]   cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]   sdi_sync_q, sdi_sync_d;
    logic                     sclk_prev_q, sclk_prev_d;
    logic                     cs_prev_q, cs_prev_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic                     armed_q, armed_d;
    logic                     cpol_q, cpol_d;
    logic                     cpha_q, cpha_d;
    logic [BIT_W-1:0]         bits_q, bits_d;
    logic [FRAME_W-1:0]       shift_q, shift_d;
    logic [FRAME_W-1:0]       mem_q [FIFO_DEPTH];
    logic [FRAME_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overflow_q, overflow_d;

    logic sclk_s, sdi_s, cs_act, cs_prev_act, sample_edge;
    logic fifo_full, pop, push, drop, settled;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign cs_act      = (cs_sync_q[SYNC_STAGES-1] == CS_ACTIVE);
    assign cs_prev_act = (cs_prev_q == CS_ACTIVE);
    assign sample_edge = (cpol_q ^ cpha_q) ? (sclk_prev_q && !sclk_s)
                                           : (!sclk_prev_q && sclk_s);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign frame_valid = (count_q != '0);
    assign pop         = frame_valid && frame_ready;
    assign settled     = (settle_q == SET_W'(SYNC_STAGES));

    assign frame_data  = mem_q[rd_ptr_q][FRAME_W-1:CH_BITS];
    assign frame_ch    = mem_q[rd_ptr_q][CH_BITS-1:0];
    assign fifo_count  = count_q;
    assign busy        = cs_act;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

    // Reception is only armed once the synchronised CS has been seen inactive
    // after reset, so a CS held active across reset release never starts a frame.
    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        settle_d    = settle_q;
        armed_d     = armed_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        bits_d      = bits_q;
        shift_d     = shift_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;

        if (!settled) settle_d = settle_q + SET_W'(1);
        if (settled && !cs_act) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (armed_q && cs_act && !cs_prev_act) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    bits_d  = '0;
                    shift_d = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    shift_d = {shift_q[FRAME_W-2:0], sdi_s};
                    if (bits_q != BIT_W'(FRAME_W + 1)) bits_d = bits_q + BIT_W'(1);
                end
                if (!cs_act) state_d = DONE;
            end
            DONE: begin
                if (bits_q == BIT_W'(FRAME_W)) begin
                    if (!fifo_full || pop) push = 1'b1;
                    else                   drop = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
        else              overflow_d = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= {SYNC_STAGES{~CS_ACTIVE}};
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= ~CS_ACTIVE;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bits_q      <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bits_q      <= bits_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
